// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and load writebacks
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int ZERO_REG = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        freeze,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [63:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [63:0] req1_data,
  output logic        req1_ready,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [63:0] WriteData,
  output logic [3:0]  wait_cnt
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  localparam logic [4:0] ZR = 5'(ZERO_REG);
  logic        starve;
  logic        xfer;
  logic [4:0]  addr;
  logic [63:0] data;
  // loads win contention until the ALU has been stalled MAX_WAIT cycles
  always_comb begin
    starve     = wait_cnt == MW;
    req0_ready = reset_n && !freeze && req0_valid && (!req1_valid || starve);
    req1_ready = reset_n && !freeze && req1_valid && !(req0_valid && starve);
    xfer       = req0_ready || req1_ready;
    addr       = req0_ready ? req0_addr : req1_addr;
    data       = req0_ready ? req0_data : req1_data;
  end
  // registered write port and ALU starvation counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      wait_cnt      <= '0;
    end else begin
      RegWrite <= xfer && addr != ZR;
      if (xfer) begin
        WriteRegister <= addr;
        WriteData     <= data;
      end
      wait_cnt <= req0_ready ? '0 :
                  (req0_valid && !freeze && !starve) ? wait_cnt + 4'd1 : wait_cnt;
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Single-write-port arbiter for the 32x64 register file. It shares the one write port (RegWrite / WriteRegister / WriteData) between two writeback requesters: req0 (ALU result) and req1 (memory load). Default priority goes to req1, with a starvation counter that forces a req0 grant. Output is registered and drives the register file write port directly.

Parameters:
MAX_WAIT, 3, consecutive stalled cycles of req0 before it is forced to win (1..15)
ZERO_REG, 31, register index hardwired to zero; writes to it are accepted and discarded

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
freeze  input  1  suspends all grants (scan/debug hold)
req0_valid  input  1  ALU writeback request
req0_addr  input  5  ALU destination register
req0_data  input  64  ALU writeback data
req0_ready  output  1  ALU request accepted this cycle
req1_valid  input  1  load writeback request
req1_addr  input  5  load destination register
req1_data  input  64  load writeback data
req1_ready  output  1  load request accepted this cycle
RegWrite  output  1  register file write enable
WriteRegister  output  5  register file write address
WriteData  output  64  register file write data
wait_cnt  output  4  current req0 starvation count (debug)

Behaviour:
- Reset (reset_n low, asynchronous): RegWrite=0, WriteRegister=0, WriteData=0, wait_cnt=0. readies are 0 while reset_n is low.
- Handshake: a transfer occurs on the rising edge where reqN_valid && reqN_ready. A requester holds valid, addr and data stable until ready. reqN_ready is combinational from valids, freeze and wait_cnt, and never depends on ready.
- At most one ready is asserted per cycle.
- Grant rules, evaluated each cycle with freeze=0:
  - only req0 valid -> req0_ready=1
  - only req1 valid -> req1_ready=1
  - both valid and wait_cnt < MAX_WAIT -> req1 wins
  - both valid and wait_cnt == MAX_WAIT -> req0 wins
- freeze=1: both readies 0, RegWrite=0 on the next edge, wait_cnt holds.
- wait_cnt update on each edge:
  - cleared to 0 when req0 transfers
  - increments (saturating at MAX_WAIT) when req0_valid && !req0_ready && !freeze
  - otherwise holds
- Output stage, registered with latency 1: on the edge of a transfer, WriteRegister <= granted addr, WriteData <= granted data, and RegWrite <= (granted addr != ZERO_REG).
  - No transfer -> RegWrite <= 0; WriteRegister and WriteData hold their previous values.
  - ZERO_REG write -> handshake completes, RegWrite stays 0, and WriteRegister/WriteData still update.
- Throughput: one write per cycle sustained. The register file always accepts, so there is no backpressure from the output.
- Same-address writes from both requesters in one cycle: serialized by the rules above. The later-granted value is the final content. Ordering between requesters is the producer's responsibility.
- Reset asserted mid-operation: pending requests are dropped, and RegWrite deasserts immediately (asynchronous). After release, the first grant is evaluated on the next edge with wait_cnt=0.

Test Plan:
- Reset: hold reset_n=0 with both valids high -> RegWrite=0, both readies 0, wait_cnt=0. Release reset_n -> req1 granted on the first edge.
- Single requester: req0 valid, addr=5, data=64'hDEAD_BEEF_0000_0001 for one cycle -> req0_ready=1 that cycle. Next cycle RegWrite=1, WriteRegister=5, WriteData matches. The cycle after, RegWrite=0.
- Contention with starvation (MAX_WAIT=3): both valid continuously with distinct addrs; req1 pulses a new request every cycle.
  - req1 granted for cycles 1-3 while wait_cnt goes 1,2,3.
  - Cycle 4: req0 granted, wait_cnt returns to 0.
  - Pattern repeats: 3 req1 writes, then 1 req0 write.
- Zero register: req1 addr=31, data=64'hFFFF_FFFF_FFFF_FFFF -> req1_ready=1, RegWrite stays 0 next cycle, WriteRegister=31.
- Freeze: both valid, freeze=1 for 4 cycles -> readies 0, RegWrite=0, wait_cnt frozen. On freeze=0, arbitration resumes from the frozen wait_cnt.
- Async reset mid-stream: assert reset_n low between edges during back-to-back writes -> RegWrite drops to 0 without waiting for a clock edge, and no write issues for the dropped requests.
